// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall scheduler.
// Holds the Tuse/Tnew type, register-zero and "source unused" encodings,
// the default mult/div latencies and the per-source hazard compare.
package hazard_stall_ctrl_pkg;

  typedef logic [1:0] tstage_t;

  localparam tstage_t    TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  localparam int MULT_CYCLES_DFLT = 5;
  localparam int DIV_CYCLES_DFLT  = 10;

  // A source conflicts with a producer when it names the producer's real
  // destination and is needed before that result becomes forwardable.
  // TUSE_NONE (3) can never be below a 2-bit Tnew, so unused sources never stall.
  function automatic logic src_hazard(input logic [4:0] src, input tstage_t tuse,
                                      input logic [4:0] dst, input tstage_t tnew);
    return (src == dst) && (dst != REG_ZERO) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Multi-cycle mult/div busy tracker. Loads the remaining latency when a
// mult/div sits in EX (a new start reloads even while busy) and counts down
// to zero. md_busy_o covers the start cycle plus the loaded number of cycles.
module md_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DFLT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DFLT,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ex_md_start_i,
  input  logic ex_md_is_div_i,
  output logic md_busy_o
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] md_cnt_q;
  logic [CNT_W-1:0] md_cnt_d;

  // Next count: a start reloads, otherwise a running count drains by one.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (ex_md_start_i) begin
      md_cnt_d = ex_md_is_div_i ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt_q != CNT_ZERO) begin
      md_cnt_d = md_cnt_q - CNT_ONE;
    end else begin
      md_cnt_d = CNT_ZERO;
    end
  end

  // Counter register, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= CNT_ZERO;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  // Busy is forced low during the reset cycle so the pipeline is released.
  assign md_busy_o = ~reset & (ex_md_start_i | (md_cnt_q != CNT_ZERO));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline, placed beside ID.
// Freezes PC and IF/ID and bubbles ID/EX when an ID source is needed before
// the EX or MEM producer can forward it, or when an MDU instruction in ID
// meets a busy mult/div unit.
// Optional build macro HAZARD_STALL_CNT_EN: enables the saturating 32-bit
// stall-cycle counter on stall_count; without it stall_count is tied to zero.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DFLT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DFLT,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [1:0]  id_rs_tuse,
  input  logic [1:0]  id_rt_tuse,
  input  logic        id_is_md,
  input  logic [4:0]  ex_dst,
  input  logic [1:0]  ex_tnew,
  input  logic [4:0]  mem_dst,
  input  logic [1:0]  mem_tnew,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_clr,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  logic reg_hazard_s;
  logic stall_s;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .clk            (clk),
    .reset          (reset),
    .ex_md_start_i  (ex_md_start),
    .ex_md_is_div_i (ex_md_is_div),
    .md_busy_o      (md_busy)
  );

  // Register RAW check of both ID sources against the EX and MEM producers.
  always_comb begin
    reg_hazard_s = src_hazard(id_rs, id_rs_tuse, ex_dst,  ex_tnew)
                 | src_hazard(id_rs, id_rs_tuse, mem_dst, mem_tnew)
                 | src_hazard(id_rt, id_rt_tuse, ex_dst,  ex_tnew)
                 | src_hazard(id_rt, id_rt_tuse, mem_dst, mem_tnew);
  end

  // Stall is held for as long as the condition lasts; released during reset.
  assign stall_s   = ~reset & (reg_hazard_s | (id_is_md & md_busy));
  assign pc_en     = ~stall_s;
  assign if_id_en  = ~stall_s;
  assign id_ex_clr = stall_s;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_comb begin
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed cases followed by
// randomized traffic compared against a cycle-indexed reference model.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_dst, mem_dst;
  logic [1:0]  id_rs_tuse, id_rt_tuse, ex_tnew, mem_tnew;
  logic        id_is_md, ex_md_start, ex_md_is_div;
  logic        pc_en, if_id_en, id_ex_clr, md_busy;
  logic [31:0] stall_count;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state: cycle index, last cycle the MDU is busy, stall tally.
  int          cyc      = 0;
  int          busy_end = -1;
  logic [31:0] m_scnt   = 32'h0;
  logic        m_stall;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse),
    .id_is_md(id_is_md), .ex_dst(ex_dst), .ex_tnew(ex_tnew),
    .mem_dst(mem_dst), .mem_tnew(mem_tnew),
    .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_clr(id_ex_clr),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit src_hz(int s, int tuse, int d, int tnew);
    return (d != 0) && (s == d) && (tuse < tnew);
  endfunction

  task automatic idle_inputs();
    reset = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; id_rs_tuse = 2'd3; id_rt_tuse = 2'd3;
    id_is_md = 1'b0; ex_dst = 5'd0; ex_tnew = 2'd0; mem_dst = 5'd0; mem_tnew = 2'd0;
    ex_md_start = 1'b0; ex_md_is_div = 1'b0;
  endtask

  // Settle, then compare every output against the model for this cycle.
  task automatic eval(input string tag);
    bit hz, busy;
    #1;
    hz = src_hz(id_rs, id_rs_tuse, ex_dst, ex_tnew) || src_hz(id_rs, id_rs_tuse, mem_dst, mem_tnew)
      || src_hz(id_rt, id_rt_tuse, ex_dst, ex_tnew) || src_hz(id_rt, id_rt_tuse, mem_dst, mem_tnew);
    busy = !reset && (ex_md_start || cyc <= busy_end);
    m_stall = !reset && (hz || (id_is_md && busy));
    chk({tag, ".pc_en"},     {31'd0, pc_en},     {31'd0, !m_stall});
    chk({tag, ".if_id_en"},  {31'd0, if_id_en},  {31'd0, !m_stall});
    chk({tag, ".id_ex_clr"}, {31'd0, id_ex_clr}, {31'd0, m_stall});
    chk({tag, ".md_busy"},   {31'd0, md_busy},   {31'd0, busy});
    chk({tag, ".stall_cnt"}, stall_count, m_scnt);
  endtask

  // Apply the clock edge to the model, then return on the next falling edge.
  task automatic adv();
    @(posedge clk);
    if (reset) begin
      busy_end = -1;
      m_scnt   = 32'h0;
    end else begin
      if (ex_md_start) busy_end = cyc + (ex_md_is_div ? 10 : 5);
`ifdef HAZARD_STALL_CNT_EN
      if (m_stall && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
`endif
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    adv();                          // first edge clears the DUT state
    eval("rst");
    chk("rst.pc_en_const", {31'd0, pc_en}, 32'd1);
    chk("rst.busy_const",  {31'd0, md_busy}, 32'd0);
    chk("rst.cnt_const",   stall_count, 32'd0);
    adv();
    idle_inputs();

    // RAW against the EX producer, then the forwardable case.
    id_rs = 5'd8; id_rs_tuse = 2'd0; ex_dst = 5'd8; ex_tnew = 2'd2;
    eval("raw_ex");
    chk("raw_ex.clr_const",  {31'd0, id_ex_clr}, 32'd1);
    chk("raw_ex.pcen_const", {31'd0, pc_en},     32'd0);
    adv();
    ex_tnew = 2'd1; id_rs_tuse = 2'd1;
    eval("raw_ex_ok");
    chk("raw_ex_ok.clr_const", {31'd0, id_ex_clr}, 32'd0);
    adv();

    // $0 never conflicts; an unused source never conflicts.
    idle_inputs();
    id_rs = 5'd0; id_rs_tuse = 2'd0; ex_dst = 5'd0; ex_tnew = 2'd2;
    eval("zero_reg");
    chk("zero_reg.clr_const", {31'd0, id_ex_clr}, 32'd0);
    adv();
    idle_inputs();
    id_rt = 5'd9; id_rt_tuse = 2'd3; mem_dst = 5'd9; mem_tnew = 2'd2;
    eval("unused");
    chk("unused.clr_const", {31'd0, id_ex_clr}, 32'd0);
    adv();

    // MEM hazard on rt, then released once the result is ready.
    idle_inputs();
    id_rt = 5'd5; id_rt_tuse = 2'd0; mem_dst = 5'd5; mem_tnew = 2'd1;
    eval("mem_rt");
    chk("mem_rt.clr_const", {31'd0, id_ex_clr}, 32'd1);
    adv();
    mem_tnew = 2'd0;
    eval("mem_rt_ok");
    chk("mem_rt_ok.clr_const", {31'd0, id_ex_clr}, 32'd0);
    adv();

    // Mult and div busy windows with an MDU instruction held in ID.
    for (int d = 0; d < 2; d++) begin
      idle_inputs();
      id_is_md = 1'b1;
      for (int k = 0; k < 13; k++) begin
        ex_md_start  = (k == 0);
        ex_md_is_div = (d == 1);
        eval(d ? "div_win" : "mult_win");
        chk(d ? "div_win.busy_const" : "mult_win.busy_const", {31'd0, md_busy},
            (k <= (d ? 10 : 5)) ? 32'd1 : 32'd0);
        adv();
      end
    end

    // Reset in the middle of a divide.
    idle_inputs();
    id_is_md = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ex_md_start = (k == 0); ex_md_is_div = 1'b1; reset = (k == 3);
      eval("rst_div");
      if (k >= 4) begin
        chk("rst_div.busy_const", {31'd0, md_busy}, 32'd0);
        chk("rst_div.cnt_const",  stall_count, 32'd0);
      end
      adv();
    end

`ifdef HAZARD_STALL_CNT_EN
    // Seven stalled cycles, then saturation from a forced preload.
    idle_inputs();
    reset = 1'b1; eval("cnt_rst"); adv();
    idle_inputs();
    id_rs = 5'd3; id_rs_tuse = 2'd0; ex_dst = 5'd3; ex_tnew = 2'd2;
    for (int k = 0; k < 7; k++) begin eval("cnt7"); adv(); end
    idle_inputs();
    eval("cnt7_done");
    chk("cnt7.const", stall_count, 32'd7);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    m_scnt = 32'hFFFF_FFFD;
    adv();
    id_rs = 5'd3; id_rs_tuse = 2'd0; ex_dst = 5'd3; ex_tnew = 2'd2;
    for (int k = 0; k < 4; k++) begin eval("sat"); adv(); end
    idle_inputs();
    eval("sat_done");
    chk("sat.const", stall_count, 32'hFFFF_FFFF);
    adv();
`endif

    // Randomized traffic on a small register set so hits are frequent.
    for (int k = 0; k < 500; k++) begin
      reset        = ($urandom_range(0, 63) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_rs_tuse   = 2'($urandom_range(0, 3));
      id_rt_tuse   = 2'($urandom_range(0, 3));
      ex_dst       = 5'($urandom_range(0, 3));
      mem_dst      = 5'($urandom_range(0, 3));
      ex_tnew      = 2'($urandom_range(0, 3));
      mem_tnew     = 2'($urandom_range(0, 3));
      id_is_md     = 1'($urandom_range(0, 1));
      ex_md_start  = ($urandom_range(0, 11) == 0);
      ex_md_is_div = 1'($urandom_range(0, 1));
      eval("rand");
      adv();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall/flush scheduler for the 5-stage pipeline.
- Compares register demand of the instruction in ID (Tuse) against producers in EX and MEM (Tnew); on a hazard it freezes PC and IF/ID and injects a bubble via the ID/EX clear.
- Owns a multi-cycle mult/div busy counter and stalls HI/LO-dependent instructions in ID while the unit is busy.
- Sits beside the ID stage; drives the PC enable, IF/ID enable and ID/EX clear input.

Parameters:
- MULT_CYCLES, 5, extra busy cycles after a mult/multu start.
- DIV_CYCLES, 10, extra busy cycles after a div/divu start.
- CNT_W, 4, width of the busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the ID instruction
- id_rt  in  5  rt field of the ID instruction
- id_rs_tuse  in  2  cycles until rs is needed; 3 = not used
- id_rt_tuse  in  2  cycles until rt is needed; 3 = not used
- id_is_md  in  1  ID instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- ex_dst  in  5  destination register of the EX instruction; 0 = none
- ex_tnew  in  2  cycles until the EX result is forwardable
- mem_dst  in  5  destination register of the MEM instruction
- mem_tnew  in  2  cycles until the MEM result is forwardable
- ex_md_start  in  1  mult/div is in EX this cycle
- ex_md_is_div  in  1  qualifies ex_md_start: 1 = div, 0 = mult
- pc_en  out  1  PC write enable
- if_id_en  out  1  IF/ID write enable
- id_ex_clr  out  1  ID/EX clear (bubble)
- md_busy  out  1  MDU busy
- stall_count  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset: md_cnt <= 0; stall_count <= 0. During the reset cycle md_busy = 0 and stall = 0, so pc_en = 1, if_id_en = 1, id_ex_clr = 0.
- Register hazard for source s in {rs, rt}, combinational, same cycle:
  - hz_ex(s) = (id_s == ex_dst) && ex_dst != 0 && id_s_tuse < ex_tnew
  - hz_mem(s) = (id_s == mem_dst) && mem_dst != 0 && id_s_tuse < mem_tnew
  - Compare Tuse and Tnew unsigned. Tuse = 3 therefore never stalls.
- MDU counter:
  - If ex_md_start, load md_cnt <= (ex_md_is_div ? DIV_CYCLES : MULT_CYCLES).
  - Else if md_cnt != 0, md_cnt <= md_cnt - 1.
  - A start while busy reloads the counter; start takes priority over decrement.
- md_busy = ex_md_start || (md_cnt != 0). It is high for N+1 cycles, from the start cycle to start+N.
- stall = any hz_ex/hz_mem on rs or rt, OR (id_is_md && md_busy).
- Outputs: pc_en = ~stall; if_id_en = ~stall; id_ex_clr = stall. All three are combinational with zero latency.
- The stall holds every cycle the condition persists, with no hysteresis. Tnew values advance in the pipeline registers, so the stall releases on its own.
- Reset mid-operation: the counter is cleared at that edge; md_busy is low from the next cycle.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: stall_count increments on every clock where stall = 1 and reset = 0. It saturates at 32'hFFFFFFFF and is cleared by reset.
- Undefined: no counter register; stall_count is tied to 32'h0.

Decomposition:
- Shared pipeline package holds:
  - TUSE_NONE = 2'd3
  - REG_ZERO = 5'd0
  - MULT_CYCLES and DIV_CYCLES defaults
  - 2-bit tuse/tnew typedef
- One sub-module, md_busy_counter, contains the counter, the load/decrement logic and md_busy. The hazard compare stays in the top.

Test Plan:
- RAW on the EX load:
  - Stimulus: id_rs = 8, id_rs_tuse = 0; ex_dst = 8, ex_tnew = 2.
  - Response: pc_en = 0, if_id_en = 0, id_ex_clr = 1.
  - Then set ex_tnew = 1 with id_rs_tuse = 1. Response: no stall.
- $0 and unused sources:
  - Stimulus: ex_dst = 0 and id_rs = 0 with tnew = 2 → no stall.
  - Stimulus: id_rt = 9, id_rt_tuse = 3, mem_dst = 9, mem_tnew = 2 → no stall.
- MEM hazard on rt:
  - Stimulus: id_rt = 5, id_rt_tuse = 0, mem_dst = 5, mem_tnew = 1.
  - Response: stall = 1. Change to mem_tnew = 0 → stall = 0.
- Mult busy window:
  - Stimulus: ex_md_start = 1, ex_md_is_div = 0 at cycle 0; id_is_md = 1 held.
  - Response: md_busy = 1 and id_ex_clr = 1 on cycles 0–5; both 0 on cycle 6.
  - Repeat with div: busy on cycles 0–10.
- Reset mid-div:
  - Stimulus: div start at cycle 0, reset at cycle 3.
  - Response: md_busy = 0 from cycle 4 and stall_count = 0.
- With HAZARD_STALL_CNT_EN defined:
  - Stimulus: 7 consecutive stall cycles.
  - Response: stall_count = 7.
  - Preload near saturation by forcing → holds at 32'hFFFFFFFF.
